// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing for the alarm sounder and the alarm-setting FSM.
package alarm_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BEEP_ON  = 2'd1,
    S_BEEP_OFF = 2'd2,
    S_SNOOZE   = 2'd3
  } sound_state_t;

  localparam int unsigned     DEF_TONE_HALF_CYC = 12_500;
  localparam int unsigned     DEF_BEEP_ON_CYC   = 12_500_000;
  localparam int unsigned     DEF_BEEP_OFF_CYC  = 12_500_000;
  localparam int unsigned     DEF_TIMEOUT_BEEPS = 120;
  localparam longint unsigned DEF_SNOOZE_CYC    = 64'd15_000_000_000;

  function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_sounder_if.sv
// Trigger/button inputs and speaker/status outputs of the alarm sounder.
interface alarm_sounder_if;
  logic alarm_triggered;
  logic btn_dismiss;
  logic btn_snooze;
  logic speaker_out;
  logic ringing;
  logic snoozed;

  modport master (
    output alarm_triggered, btn_dismiss, btn_snooze,
    input  speaker_out, ringing, snoozed
  );

  modport slave (
    input  alarm_triggered, btn_dismiss, btn_snooze,
    output speaker_out, ringing, snoozed
  );
endinterface

// File: rtl/alarm_sounder_tone_gen.sv
// Square-wave tone generator: phase toggles every half_cyc enabled cycles, held at 0 when disabled.
module tone_gen #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] half_cyc,
  output logic         phase
);

  logic [W-1:0] r_cnt;
  logic         r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == half_cyc - W'(1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/alarm_sounder.sv
// Alarm sounder: latches the trigger pulse and drives a gated beeping tone until dismiss or timeout.
// Snooze support is built only when ALARM_SOUNDER_SNOOZE_EN is defined.
module alarm_sounder
  import alarm_pkg::*;
#(
  parameter int unsigned     TONE_HALF_CYC = DEF_TONE_HALF_CYC,
  parameter int unsigned     BEEP_ON_CYC   = DEF_BEEP_ON_CYC,
  parameter int unsigned     BEEP_OFF_CYC  = DEF_BEEP_OFF_CYC,
  parameter int unsigned     TIMEOUT_BEEPS = DEF_TIMEOUT_BEEPS,
  parameter longint unsigned SNOOZE_CYC    = DEF_SNOOZE_CYC
) (
  input  logic            clk,
  input  logic            reset,
  alarm_sounder_if.slave  bus
);

  // state      | meaning
  // S_IDLE     | silent, waiting for alarm_triggered
  // S_BEEP_ON  | tone gated on for BEEP_ON_CYC cycles
  // S_BEEP_OFF | silence for BEEP_OFF_CYC cycles, ends one beep period
  // S_SNOOZE   | silence for SNOOZE_CYC cycles, then rings again

`ifdef ALARM_SOUNDER_SNOOZE_EN
  localparam longint unsigned SEG_MAX = max2(max2(BEEP_ON_CYC, BEEP_OFF_CYC), SNOOZE_CYC);
`else
  localparam longint unsigned SEG_MAX = max2(BEEP_ON_CYC, BEEP_OFF_CYC);
`endif
  localparam int SW = $clog2(SEG_MAX + 1);
  localparam int BW = $clog2(TIMEOUT_BEEPS + 1);
  localparam int TW = $clog2(TONE_HALF_CYC + 1);

  localparam logic [SW-1:0] ON_LAST   = SW'(BEEP_ON_CYC - 1);
  localparam logic [SW-1:0] OFF_LAST  = SW'(BEEP_OFF_CYC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(TIMEOUT_BEEPS - 1);
  localparam logic [TW-1:0] TONE_HALF = TW'(TONE_HALF_CYC);

  sound_state_t  r_state;
  logic [SW-1:0] r_seg_cnt;
  logic [BW-1:0] r_beep_cnt;
  logic          r_dismiss_prev;
  logic          w_dismiss_edge;
  logic          w_snooze_edge;
  logic          w_tone_en;
  logic          w_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dismiss_prev <= 1'b0;
    else       r_dismiss_prev <= bus.btn_dismiss;
  end
  assign w_dismiss_edge = bus.btn_dismiss & ~r_dismiss_prev;

`ifdef ALARM_SOUNDER_SNOOZE_EN
  logic r_snooze_prev;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_snooze_prev <= 1'b0;
    else       r_snooze_prev <= bus.btn_snooze;
  end
  assign w_snooze_edge = bus.btn_snooze & ~r_snooze_prev;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = bus.btn_snooze;
  assign w_snooze_edge   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_seg_cnt  <= '0;
      r_beep_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.alarm_triggered) begin
            r_state    <= S_BEEP_ON;
            r_seg_cnt  <= '0;
            r_beep_cnt <= '0;
          end
        end
        S_BEEP_ON: begin
          if (w_dismiss_edge) begin
            r_state   <= S_IDLE;
            r_seg_cnt <= '0;
          end else if (w_snooze_edge) begin
            r_state   <= S_SNOOZE;
            r_seg_cnt <= '0;
          end else if (r_seg_cnt == ON_LAST) begin
            r_state   <= S_BEEP_OFF;
            r_seg_cnt <= '0;
          end else begin
            r_seg_cnt <= r_seg_cnt + SW'(1);
          end
        end
        S_BEEP_OFF: begin
          if (w_dismiss_edge) begin
            r_state   <= S_IDLE;
            r_seg_cnt <= '0;
          end else if (w_snooze_edge) begin
            r_state   <= S_SNOOZE;
            r_seg_cnt <= '0;
          end else if (r_seg_cnt == OFF_LAST) begin
            r_seg_cnt <= '0;
            if (r_beep_cnt == BEEP_LAST) begin
              r_state    <= S_IDLE;
              r_beep_cnt <= '0;
            end else begin
              r_state    <= S_BEEP_ON;
              r_beep_cnt <= r_beep_cnt + BW'(1);
            end
          end else begin
            r_seg_cnt <= r_seg_cnt + SW'(1);
          end
        end
`ifdef ALARM_SOUNDER_SNOOZE_EN
        S_SNOOZE: begin
          if (w_dismiss_edge) begin
            r_state   <= S_IDLE;
            r_seg_cnt <= '0;
          end else if (bus.alarm_triggered || (r_seg_cnt == SW'(SNOOZE_CYC - 1))) begin
            r_state    <= S_BEEP_ON;
            r_seg_cnt  <= '0;
            r_beep_cnt <= '0;
          end else begin
            r_seg_cnt <= r_seg_cnt + SW'(1);
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_seg_cnt  <= '0;
          r_beep_cnt <= '0;
        end
      endcase
    end
  end

  // Tone runs only while BEEP_ON continues next cycle, so the phase is already 0 on any exit.
  assign w_tone_en = (r_state == S_BEEP_ON) & ~w_dismiss_edge & ~w_snooze_edge &
                     (r_seg_cnt != ON_LAST);

  tone_gen #(.W(TW)) u_tone (
    .clk      (clk),
    .reset    (reset),
    .en       (w_tone_en),
    .half_cyc (TONE_HALF),
    .phase    (w_phase)
  );

  assign bus.speaker_out = (r_state == S_BEEP_ON) & w_phase;
  assign bus.ringing     = (r_state == S_BEEP_ON) | (r_state == S_BEEP_OFF);
`ifdef ALARM_SOUNDER_SNOOZE_EN
  assign bus.snoozed     = (r_state == S_SNOOZE);
`else
  assign bus.snoozed     = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sounder.sv
// Directed bench for alarm_sounder with short timing; snooze cases need ALARM_SOUNDER_SNOOZE_EN.
module tb_alarm_sounder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alarm_sounder_if bus();

  alarm_sounder #(
    .TONE_HALF_CYC (2),
    .BEEP_ON_CYC   (8),
    .BEEP_OFF_CYC  (8),
    .TIMEOUT_BEEPS (3),
    .SNOOZE_CYC    (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic trig;
    logic dis;
    logic snz;
    logic spk;
    logic ring;
    logic snzd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic t, d, s, spk, ring, snzd);
    vec_t v;
    v.trig = t; v.dis = d; v.snz = s;
    v.spk = spk; v.ring = ring; v.snzd = snzd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: {spk,ring,snoozed} got %03b expected %03b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the negedge, get sampled at the next posedge, outputs compared at the following negedge.
  task automatic step(input logic t, input logic d, input logic s);
    bus.alarm_triggered = t;
    bus.btn_dismiss     = d;
    bus.btn_snooze      = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] outs();
    return {bus.speaker_out, bus.ringing, bus.snoozed};
  endfunction

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;

    // Three full beeps to timeout, with ignored re-triggers mid-cadence.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++)
        vecs.push_back(mk((b == 0 && (k == 0 || k == 3)), 1'b0, 1'b0, ((k >> 1) & 1) != 0, 1'b1, 1'b0));
      for (int k = 0; k < 8; k++)
        vecs.push_back(mk((b == 1 && k == 2), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Dismiss edge at cycle 5, then held for ten cycles.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k < 5; k++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, ((k >> 1) & 1) != 0, 1'b1, 1'b0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    // Trigger while dismiss is still held: no edge, so it rings; a fresh press stops it.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    reset = 1'b1;
    bus.alarm_triggered = 1'b0;
    bus.btn_dismiss     = 1'b0;
    bus.btn_snooze      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 3'b000);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("idle_after_reset", outs(), 3'b000);

    foreach (vecs[i]) begin
      step(vecs[i].trig, vecs[i].dis, vecs[i].snz);
      chk($sformatf("vec%0d", i), outs(), {vecs[i].spk, vecs[i].ring, vecs[i].snzd});
    end

    // Async reset in the middle of a tone-high cycle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("pre_reset_tone_high", outs(), 3'b110);
    #2 reset = 1'b1;
    #1 chk("reset_mid_ring", outs(), 3'b000);
    @(negedge clk);
    chk("reset_held", outs(), 3'b000);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_trig", outs(), 3'b010);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("post_reset_tone", outs(), 3'b110);
    step(1'b0, 1'b1, 1'b0);
    chk("post_reset_dismiss", outs(), 3'b000);
    step(1'b0, 1'b0, 1'b0);

`ifdef ALARM_SOUNDER_SNOOZE_EN
    // Snooze in BEEP_OFF, full snooze length, then a complete 3-beep cadence.
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    chk("in_beep_off", outs(), 3'b010);
    step(1'b0, 1'b0, 1'b1);
    chk("snooze_enter", outs(), 3'b001);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus.snoozed) cnt++;
      else break;
    end
    chk_int("snooze_len", cnt, 20);
    chk("snooze_exit", outs(), 3'b010);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.ringing) cnt++;
      else break;
    end
    chk_int("ring_after_snooze", cnt, 48);
    chk("timeout_after_snooze", outs(), 3'b000);

    // Dismiss beats snooze in the same cycle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("dismiss_over_snooze", outs(), 3'b000);
    step(1'b0, 1'b0, 1'b0);
    // Trigger during SNOOZE restarts ringing at once.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("snooze_from_on", outs(), 3'b001);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("trig_in_snooze", outs(), 3'b010);
    step(1'b0, 1'b1, 1'b0);
    chk("dismiss_after_retrig", outs(), 3'b000);
    step(1'b0, 1'b0, 1'b0);
`else
    // Without snooze support the button does nothing.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("snooze_ignored", outs(), 3'b010);
    step(1'b0, 1'b0, 1'b0);
    chk("snooze_ignored_tone", outs(), 3'b110);
    step(1'b0, 1'b1, 1'b0);
    chk("dismiss_no_snooze", outs(), 3'b000);
    step(1'b0, 1'b0, 1'b0);
    cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
